dd_pd_multimode: RTL and testbench

//  Decision-directed carrier phase detector for the QPSK/16QAM/64QAM receiver.

---
 rtl/dd_pkg.sv | 27 ++
 rtl/dd_recip_lut.sv | 40 ++++
 rtl/dd_pd_multimode.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dd_pd_multimode.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dd_pkg.sv
// Shared definitions for the decision-directed multimode phase detector.
//  - constellation mode encodings (the reserved code 11 is folded onto 16QAM by the top)
//  - level_t: a decided constellation level per axis, signed odd value in -7..7
//  - lock_state_t: carrier lock detector states
//  - energy(): symbol energy i^2 + q^2 of a decided point, always in 2..98
package dd_pkg;

    localparam logic [1:0] MODE_QPSK = 2'b00;
    localparam logic [1:0] MODE_16   = 2'b01;
    localparam logic [1:0] MODE_64   = 2'b10;

    typedef logic signed [3:0] level_t;

    typedef enum logic {ACQ, LOCK} lock_state_t;

    // Levels are widened before squaring so 7*7 does not wrap in 4 bits.
    function automatic logic [6:0] energy(input level_t i, input level_t q);
        logic signed [7:0] ie;
        logic signed [7:0] qe;
        logic signed [7:0] e;
        ie = 8'(i);
        qe = 8'(q);
        e  = ie * ie + qe * qe;
        return e[6:0];
    endfunction

endpackage

// File: rtl/dd_recip_lut.sv
// Reciprocal table for the phase detector normalisation.
// Returns recip = round(SCALE * 2^FB / E) for every energy E a decided
// point can have; any other code returns 0.
// Ports:
//  sym_energy in  7   symbol energy i^2 + q^2
//  recip      out 17  unsigned reciprocal with FB fractional bits
module dd_recip_lut
    import dd_pkg::*;
#(
    parameter int SCALE = 90,
    parameter int FB    = 10
) (
    input  logic [6:0]  sym_energy,
    output logic [16:0] recip
);

    // Round-to-nearest integer division; only ever called with constant
    // arguments, so every entry elaborates to a fixed value.
    function automatic logic [16:0] rdiv(input int e);
        return 17'((2 * SCALE * (2 ** FB) + e) / (2 * e));
    endfunction

    // Only the nine energies reachable from odd levels in -7..7 are stored.
    always_comb begin
        recip = '0;
        case (sym_energy)
            7'd2:    recip = rdiv(2);
            7'd10:   recip = rdiv(10);
            7'd18:   recip = rdiv(18);
            7'd26:   recip = rdiv(26);
            7'd34:   recip = rdiv(34);
            7'd50:   recip = rdiv(50);
            7'd58:   recip = rdiv(58);
            7'd74:   recip = rdiv(74);
            7'd98:   recip = rdiv(98);
            default: recip = '0;
        endcase
    end

endmodule

// File: rtl/dd_pd_multimode.sv
// Decision-directed carrier phase detector for QPSK/16QAM/64QAM with a
// hysteretic lock detector. Three pipeline stages, one symbol per clock max:
//  S1 slices (yi,yq) to the nearest point and forms i*yq and q*yi,
//  S2 forms the cross difference and looks up SCALE*2^FB/E,
//  S3 scales, rounds and saturates to pd and advances the lock detector.
// Ports:
//  clk      in  1   system clock
//  rst      in  1   asynchronous reset, active high
//  bitsync  in  1   symbol strobe, samples yi/yq/mode when high
//  mode     in  2   00 QPSK, 01 16QAM, 10 64QAM, 11 treated as 16QAM
//  yi, yq   in  DW  signed symbol-rate samples
//  pd       out PW  signed phase error, held between updates
//  pd_valid out 1   one-clock pulse when pd updates
//  sym_i/q  out 4   decided levels, signed odd values in -7..7
//  lock     out 1   carrier lock indication
module dd_pd_multimode
    import dd_pkg::*;
#(
    parameter int DW       = 27,
    parameter int PW       = 34,
    parameter int THR      = 12000000,
    parameter int SCALE    = 90,
    parameter int FB       = 10,
    parameter int LOCK_THR = 4000000,
    parameter int LOCK_N   = 64,
    parameter int UNLOCK_N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bitsync,
    input  logic [1:0]           mode,
    input  logic signed [DW-1:0] yi,
    input  logic signed [DW-1:0] yq,
    output logic signed [PW-1:0] pd,
    output logic                 pd_valid,
    output logic signed [3:0]    sym_i,
    output logic signed [3:0]    sym_q,
    output logic                 lock
);

    localparam int AW = DW + 4;
    localparam int MW = DW + 21;
    localparam int CW = $clog2(((LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N) + 1);

    localparam logic signed [DW-1:0] T1 = DW'(THR);
    localparam logic signed [DW-1:0] T2 = DW'(2 * THR);
    localparam logic signed [DW-1:0] T3 = DW'(3 * THR);

    localparam logic signed [MW-1:0] HALF     = MW'(1) <<< (FB - 1);
    localparam logic signed [PW-1:0] PD_MAX   = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [MW-1:0] SAT_HI   = MW'(PD_MAX);
    localparam logic signed [MW-1:0] SAT_LO   = -SAT_HI;
    localparam logic signed [PW-1:0] LOCK_LIM = PW'(LOCK_THR);

    // Count thresholds below y (zero threshold inclusive, others strict)
    // and map the count k to level 2k-(L-1). 4-bit wraparound of the
    // subtraction yields the correct two's-complement level.
    function automatic level_t slice(input logic signed [DW-1:0] y, input logic [1:0] md);
        logic [2:0] k;
        level_t     lvl;
        k = '0;
        if (!y[DW-1]) k = k + 3'd1;
        case (md)
            MODE_QPSK: lvl = {k, 1'b0} - 4'd1;
            MODE_64: begin
                if (y > -T3) k = k + 3'd1;
                if (y > -T2) k = k + 3'd1;
                if (y > -T1) k = k + 3'd1;
                if (y > T1)  k = k + 3'd1;
                if (y > T2)  k = k + 3'd1;
                if (y > T3)  k = k + 3'd1;
                lvl = {k, 1'b0} - 4'd7;
            end
            default: begin
                if (y > -T1) k = k + 3'd1;
                if (y > T1)  k = k + 3'd1;
                lvl = {k, 1'b0} - 4'd3;
            end
        endcase
        return lvl;
    endfunction

    // Multiply by a level with |l| <= 7 using shift-add on the magnitude,
    // then restore the sign.
    function automatic logic signed [DW+2:0] lvl_mul(input level_t l, input logic signed [DW-1:0] y);
        logic signed [DW+2:0] ye;
        logic signed [DW+2:0] acc;
        logic [2:0]           m;
        ye  = (DW+3)'(y);
        m   = 3'(l[3] ? -l : l);
        acc = '0;
        if (m[0]) acc = acc + ye;
        if (m[1]) acc = acc + (ye <<< 1);
        if (m[2]) acc = acc + (ye <<< 2);
        return l[3] ? -acc : acc;
    endfunction

    logic [1:0]            md_norm;
    level_t                cur_i;
    level_t                cur_q;
    logic                  s1_valid;
    logic [1:0]            s1_mode;
    logic signed [DW+2:0]  s1_pi;
    logic signed [DW+2:0]  s1_pq;
    logic [6:0]            s1_energy;
    logic [16:0]           lut_recip;
    logic                  s2_valid;
    logic [1:0]            s2_mode;
    logic signed [AW-1:0]  s2_aiq;
    logic [16:0]           s2_recip;
    logic signed [MW-1:0]  prod;
    logic signed [MW-1:0]  shifted;
    logic signed [PW-1:0]  pd_next;
    logic signed [PW-1:0]  pd_abs;
    logic                  good;
    logic                  have_mode;
    logic [1:0]            last_mode;
    logic                  mode_chg;
    lock_state_t           state;
    lock_state_t           state_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;

    // Reserved mode 11 is folded onto 16QAM so it also counts as the same
    // mode for lock purposes.
    always_comb begin
        md_norm = (mode == 2'b11) ? MODE_16 : mode;
        cur_i   = slice(yi, md_norm);
        cur_q   = slice(yq, md_norm);
    end

    // S1: capture the decision, the mode and both cross products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_QPSK;
            sym_i    <= '0;
            sym_q    <= '0;
            s1_pi    <= '0;
            s1_pq    <= '0;
        end else begin
            s1_valid <= bitsync;
            if (bitsync) begin
                s1_mode <= md_norm;
                sym_i   <= cur_i;
                sym_q   <= cur_q;
                s1_pi   <= lvl_mul(cur_i, yq);
                s1_pq   <= lvl_mul(cur_q, yi);
            end
        end
    end

    assign s1_energy = energy(sym_i, sym_q);

    dd_recip_lut #(
        .SCALE (SCALE),
        .FB    (FB)
    ) u_recip_lut (
        .sym_energy (s1_energy),
        .recip      (lut_recip)
    );

    // S2: cross difference (one extra bit, cannot overflow) and reciprocal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= MODE_QPSK;
            s2_aiq   <= '0;
            s2_recip <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode  <= s1_mode;
                s2_aiq   <= AW'(s1_pi) - AW'(s1_pq);
                s2_recip <= lut_recip;
            end
        end
    end

    // S3 datapath: scale, round half up, clamp symmetrically to PW bits.
    // Mode changes are detected against the previous symbol that reached
    // this stage, which is the same ordering as at capture time.
    always_comb begin
        prod    = MW'(s2_aiq) * $signed(MW'(s2_recip));
        shifted = (prod + HALF) >>> FB;
        if (shifted > SAT_HI) begin
            pd_next = PD_MAX;
        end else if (shifted < SAT_LO) begin
            pd_next = -PD_MAX;
        end else begin
            pd_next = shifted[PW-1:0];
        end
        pd_abs   = pd_next[PW-1] ? -pd_next : pd_next;
        good     = pd_abs < LOCK_LIM;
        mode_chg = have_mode && (s2_mode != last_mode);
    end

    // S3 registers: phase error output and the last mode seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pd        <= '0;
            pd_valid  <= 1'b0;
            have_mode <= 1'b0;
            last_mode <= MODE_QPSK;
        end else begin
            pd_valid <= s2_valid;
            if (s2_valid) begin
                pd        <= pd_next;
                have_mode <= 1'b1;
                last_mode <= s2_mode;
            end
        end
    end

    // Lock detector state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACQ;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Lock detector transitions: runs of good symbols acquire, runs of bad
    // symbols drop lock; a mode change always restarts acquisition.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (s2_valid) begin
            if (mode_chg) begin
                state_next = ACQ;
                cnt_next   = '0;
            end else begin
                case (state)
                    ACQ: begin
                        if (!good) begin
                            cnt_next = '0;
                        end else if (cnt == CW'(LOCK_N - 1)) begin
                            state_next = LOCK;
                            cnt_next   = '0;
                        end else if (cnt != '1) begin
                            cnt_next = cnt + CW'(1);
                        end
                    end
                    LOCK: begin
                        if (good) begin
                            cnt_next = '0;
                        end else if (cnt == CW'(UNLOCK_N - 1)) begin
                            state_next = ACQ;
                            cnt_next   = '0;
                        end else if (cnt != '1) begin
                            cnt_next = cnt + CW'(1);
                        end
                    end
                    default: begin
                        state_next = ACQ;
                        cnt_next   = '0;
                    end
                endcase
            end
        end
    end

    assign lock = (state == LOCK);

endmodule

// File: tb/tb_dd_pd_multimode.sv
`timescale 1ns/1ps
// Testbench for dd_pd_multimode: directed spec vectors, threshold edges,
// lock/unlock sequences, randomized streams and a reset mid-burst, all
// checked against a behavioural model of slicing, pd and lock.
module tb_dd_pd_multimode;

    localparam longint THR      = 12000000;
    localparam longint SCALE    = 90;
    localparam longint LOCK_THR = 4000000;
    localparam longint PD_LIM   = 64'sd8589934591;

    logic               clk;
    logic               rst;
    logic               bitsync;
    logic [1:0]         mode;
    logic signed [26:0] yi;
    logic signed [26:0] yq;
    logic signed [33:0] pd;
    logic               pd_valid;
    logic signed [3:0]  sym_i;
    logic signed [3:0]  sym_q;
    logic               lock;

    dd_pd_multimode dut (
        .clk      (clk),
        .rst      (rst),
        .bitsync  (bitsync),
        .mode     (mode),
        .yi       (yi),
        .yq       (yq),
        .pd       (pd),
        .pd_valid (pd_valid),
        .sym_i    (sym_i),
        .sym_q    (sym_q),
        .lock     (lock)
    );

    typedef struct {
        longint pd;
        bit     lock;
        int     due;
    } exp_t;

    exp_t   exp_q[$];
    int     total;
    int     bad;
    int     edge_cnt;
    longint last_pd;
    bit     m_locked;
    int     m_cnt;
    bit     m_have;
    int     m_last;

    initial clk = 1'b0;
    always #62.5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Nearest-point decision from the threshold grid m*THR.
    function automatic int model_slice(input longint y, input int levels);
        int h;
        int k;
        h = levels / 2 - 1;
        k = 0;
        for (int m = -h; m <= h; m++) begin
            if (m == 0 ? (y >= 0) : (y > m * THR)) k++;
        end
        return 2 * k - (levels - 1);
    endfunction

    function automatic longint floor_div(input longint n, input longint d);
        longint r;
        r = n / d;
        if ((n % d != 0) && (n < 0)) r = r - 1;
        return r;
    endfunction

    function automatic longint model_pd(input int i, input int q, input longint y_i, input longint y_q);
        longint aiq;
        longint e;
        longint rcp;
        longint v;
        aiq = i * y_q - q * y_i;
        e   = i * i + q * q;
        rcp = (2 * SCALE * 1024 + e) / (2 * e);
        v   = floor_div(aiq * rcp + 512, 1024);
        if (v > PD_LIM) v = PD_LIM;
        if (v < -PD_LIM) v = -PD_LIM;
        return v;
    endfunction

    task automatic modelLock(input int nm, input longint p);
        bit g;
        g = ((p < 0) ? -p : p) < LOCK_THR;
        if (m_have && nm != m_last) begin
            m_locked = 0;
            m_cnt    = 0;
        end else if (!m_locked) begin
            m_cnt = g ? m_cnt + 1 : 0;
            if (m_cnt == 64) begin
                m_locked = 1;
                m_cnt    = 0;
            end
        end else begin
            m_cnt = g ? 0 : m_cnt + 1;
            if (m_cnt == 16) begin
                m_locked = 0;
                m_cnt    = 0;
            end
        end
        m_have = 1;
        m_last = nm;
    endtask

    task automatic modelReset();
        m_locked = 0;
        m_cnt    = 0;
        m_have   = 0;
        m_last   = 0;
    endtask

    // Present one symbol; leaves bitsync high so calls chain back-to-back.
    // With fixed=1 the given decisions and pd are the expected values.
    task automatic applyStimulus(input int md, input longint y_i, input longint y_q,
                                 input bit fixed, input int fsi, input int fsq, input longint fpd);
        int     nm;
        int     lv;
        int     si;
        int     sq;
        longint p;
        bitsync = 1'b1;
        mode    = md[1:0];
        yi      = y_i[26:0];
        yq      = y_q[26:0];
        @(posedge clk);
        #1;
        nm = (md == 3) ? 1 : md;
        lv = (nm == 0) ? 2 : (nm == 1) ? 4 : 8;
        si = fixed ? fsi : model_slice(y_i, lv);
        sq = fixed ? fsq : model_slice(y_q, lv);
        p  = fixed ? fpd : model_pd(si, sq, y_i, y_q);
        checkOutput("sym_i", sym_i, si);
        checkOutput("sym_q", sym_q, sq);
        modelLock(nm, p);
        exp_q.push_back('{pd: p, lock: m_locked, due: edge_cnt + 2});
    endtask

    task automatic idle(input int n);
        bitsync = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int rnd_lvl(input int lv);
        return 2 * int'($urandom_range(0, lv - 1)) - (lv - 1);
    endfunction

    function automatic longint rnd_y();
        return longint'($urandom_range(0, 134217727)) - 64'sd67108864;
    endfunction

    task automatic goodSym(input int md);
        int lv;
        lv = (md == 0) ? 2 : (md == 2) ? 8 : 4;
        applyStimulus(md, rnd_lvl(lv) * 6000000 + longint'($urandom_range(0, 20000)) - 10000,
                      rnd_lvl(lv) * 6000000 + longint'($urandom_range(0, 20000)) - 10000, 0, 0, 0, 0);
    endtask

    task automatic badSym();
        applyStimulus(1, 20000000 + longint'($urandom_range(0, 200000)) - 100000,
                      5000000 + longint'($urandom_range(0, 200000)) - 100000, 0, 0, 0, 0);
    endtask

    // Scoreboard: every pd_valid must match the oldest outstanding symbol on
    // the expected cycle; between updates pd must hold its last value.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pd_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("latency", edge_cnt, e.due);
                    checkOutput("pd", pd, e.pd);
                    checkOutput("lock", lock, e.lock);
                    last_pd = e.pd;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                    checkOutput("missing_valid", 0, 1);
                    e = exp_q.pop_front();
                end
                checkOutput("pd_hold", pd, last_pd);
            end
        end
    end

    initial begin
        #(125 * 30000);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total    = 0;
        bad      = 0;
        edge_cnt = 0;
        last_pd  = 0;
        modelReset();
        rst      = 1'b1;
        bitsync  = 1'b0;
        mode     = 2'b00;
        yi       = '0;
        yq       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pd", pd, 0);
        checkOutput("rst_pd_valid", pd_valid, 0);
        checkOutput("rst_lock", lock, 0);
        checkOutput("rst_sym_i", sym_i, 0);
        checkOutput("rst_sym_q", sym_q, 0);
        rst = 1'b0;
        idle(2);

        // Directed vectors with hand-derived expectations.
        applyStimulus(1, 20000000, 5000000, 1, 3, 1, -45000000);
        idle(4);
        applyStimulus(0, 1000, -3000, 1, 1, -1, -90000);
        idle(4);
        applyStimulus(2, 40000000, -13000000, 1, 7, -3, 45000977);
        idle(4);
        applyStimulus(2, 36000000, -36000000, 1, 5, -7, 87539063);
        // Threshold edges back-to-back, including reserved mode 11.
        applyStimulus(1, 12000000, 0, 1, 1, 1, -540000000);
        applyStimulus(1, -12000000, 0, 1, -3, 1, 108000000);
        applyStimulus(1, 0, 0, 1, 1, 1, 0);
        applyStimulus(3, -12000000, 12000000, 1, -3, 1, -216000000);
        idle(4);

        // Lock acquisition, hysteresis, loss and mode-change drop.
        badSym();
        repeat (64) goodSym(1);
        idle(4);
        checkOutput("lock_after_64_good", lock, 1);
        repeat (15) badSym();
        goodSym(1);
        idle(4);
        checkOutput("lock_after_15_bad", lock, 1);
        repeat (16) badSym();
        idle(4);
        checkOutput("lock_after_16_bad", lock, 0);
        repeat (64) goodSym(1);
        idle(4);
        checkOutput("relock", lock, 1);
        goodSym(2);
        idle(4);
        checkOutput("lock_mode_change", lock, 0);

        // Ten back-to-back random symbols.
        for (int n = 0; n < 10; n++) applyStimulus(int'($urandom_range(0, 3)), rnd_y(), rnd_y(), 0, 0, 0, 0);
        idle(4);

        // Random stream with random gaps, mixing near-point and arbitrary samples.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 0) goodSym(int'($urandom_range(0, 2)));
            else applyStimulus(int'($urandom_range(0, 3)), rnd_y(), rnd_y(), 0, 0, 0, 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        // Reset in the middle of a burst discards everything in flight.
        for (int n = 0; n < 6; n++) goodSym(1);
        rst = 1'b1;
        exp_q.delete();
        last_pd = 0;
        modelReset();
        #1;
        checkOutput("midrst_pd", pd, 0);
        checkOutput("midrst_pd_valid", pd_valid, 0);
        checkOutput("midrst_lock", lock, 0);
        repeat (2) @(posedge clk);
        #1;
        bitsync = 1'b0;
        rst     = 1'b0;
        idle(6);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
